// File: rtl/logIP_pkg.sv
// logIP_pkg: shared opcode constants, sequencer state encoding and opcode helpers
// for the UART command sequencer.
package logIP_pkg;

  // Short opcodes carry no argument bytes
  localparam logic [7:0] CMD_RESET = 8'h00;
  localparam logic [7:0] CMD_RUN   = 8'h01;
  localparam logic [7:0] CMD_ID    = 8'h02;
  localparam logic [7:0] CMD_META  = 8'h04;

  // Opcodes 0x80-0xFF form the long set: four little-endian argument bytes follow
  localparam logic [7:0] CMD_LONG_BASE = 8'h80;

  // Number of argument bytes that follow a long opcode
  localparam int unsigned CMD_ARG_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2
  } seqState_e;

  // A long opcode is any value at or above the long-set base (bit 7 set)
  function automatic logic isLongOpcode(input logic [7:0] op);
    return (op >= CMD_LONG_BASE);
  endfunction

endpackage

// File: rtl/cmd_timeout.sv
// cmd_timeout: idle-cycle watchdog for a partially received long command.
// Counts enabled cycles since the last clear; expire_o flags the cycle in which
// TIMEOUT_CYCLES idle cycles have elapsed. Only built with LOGIP_CMD_TIMEOUT_EN.
module cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  assign expire_o = enable_i && !clear_i && (count_q == LastCount);

  // Restart on every byte or whenever the sequencer is not collecting; hold at expiry
  always_comb begin
    count_d = count_q;
    if (clear_i || !enable_i) begin
      count_d = '0;
    end else if (!expire_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // Idle-cycle counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: assembles UART bytes into commands. A byte with bit 7 clear is a
// complete short command; a byte with bit 7 set opens a long command followed by a
// 32-bit little-endian argument. Commands are presented with a valid/ready handshake.
// Optional feature: define LOGIP_CMD_TIMEOUT_EN to abandon a long command after
// TIMEOUT_CYCLES idle clocks between bytes (abort_o pulses); otherwise COLLECT waits forever.
module cmd_sequencer
  import logIP_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_stb_i,
  input  logic [7:0]  rx_data_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [7:0]  opcode_o,
  output logic [31:0] cmd_data_o,
  output logic        is_long_o,
  output logic        overrun_o,
  output logic        abort_o,
  output logic        busy_o
);

  seqState_e   state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [31:0] cmdData_q, cmdData_d;
  logic        overrun_q, overrun_d;
  logic        handshake;
  logic        startCmd;

`ifdef LOGIP_CMD_TIMEOUT_EN
  logic abort_q, abort_d;
  logic timerExpire;

  cmd_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) uTimeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (rx_stb_i),
    .enable_i (state_q == COLLECT),
    .expire_o (timerExpire)
  );

  assign abort_o = abort_q;
`else
  assign abort_o = 1'b0;

  // TIMEOUT_CYCLES has no effect in this build; this empty block only references it
  if (TIMEOUT_CYCLES == 0) begin : gNoTimer
  end
`endif

  assign handshake = (state_q == ISSUE) && cmd_ready_i;
  // A byte starts a new command from IDLE, or in the very cycle the pending one is taken
  assign startCmd  = rx_stb_i && ((state_q == IDLE) || handshake);

  // Next-state logic: opcode capture, argument assembly, handshake and overrun detection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opcode_d  = opcode_q;
    cmdData_d = cmdData_q;
    overrun_d = 1'b0;
`ifdef LOGIP_CMD_TIMEOUT_EN
    abort_d   = 1'b0;
`endif
    if (startCmd) begin
      opcode_d  = rx_data_i;
      cmdData_d = '0;
      cnt_d     = '0;
      state_d   = isLongOpcode(rx_data_i) ? COLLECT : ISSUE;
    end else begin
      case (state_q)
        COLLECT: begin
          if (rx_stb_i) begin
            cmdData_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
            if (cnt_q == 2'(CMD_ARG_BYTES - 1)) begin
              state_d = ISSUE;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
`ifdef LOGIP_CMD_TIMEOUT_EN
          else if (timerExpire) begin
            state_d = IDLE;
            cnt_d   = '0;
            abort_d = 1'b1;
          end
`endif
        end
        ISSUE: begin
          if (handshake) begin
            state_d = IDLE;
          end else if (rx_stb_i) begin
            overrun_d = 1'b1;
          end
        end
        IDLE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset discards any partial or pending command
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opcode_q  <= '0;
      cmdData_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opcode_q  <= opcode_d;
      cmdData_q <= cmdData_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef LOGIP_CMD_TIMEOUT_EN
  // One-cycle abort pulse register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_d;
    end
  end
`endif

  assign cmd_valid_o = (state_q == ISSUE);
  assign busy_o      = (state_q != IDLE);
  assign opcode_o    = opcode_q;
  assign cmd_data_o  = cmdData_q;
  assign is_long_o   = opcode_q[7];
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: directed-vector bench for cmd_sequencer with hand-computed
// expectations. Inputs change and outputs are sampled on the falling clock edge.
module tb_cmd_sequencer;
  import logIP_pkg::*;

  logic        clk;
  logic        rst;
  logic        rxStb;
  logic [7:0]  rxData;
  logic        cmdValid;
  logic        cmdReady;
  logic [7:0]  opcode;
  logic [31:0] cmdData;
  logic        isLong;
  logic        overrun;
  logic        abort;
  logic        busy;

  int checks = 0;
  int errors = 0;

  cmd_sequencer #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_stb_i    (rxStb),
    .rx_data_i   (rxData),
    .cmd_valid_o (cmdValid),
    .cmd_ready_i (cmdReady),
    .opcode_o    (opcode),
    .cmd_data_o  (cmdData),
    .is_long_o   (isLong),
    .overrun_o   (overrun),
    .abort_o     (abort),
    .busy_o      (busy)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value and count the result
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Strobe one byte for exactly one cycle; returns one falling edge after the capturing edge
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rxStb  = 1'b1;
    rxData = b;
    @(negedge clk);
    rxStb  = 1'b0;
    rxData = 8'h00;
  endtask

  // All outputs packed for compact reset checks
  function automatic logic [31:0] flags();
    return {26'd0, cmdValid, isLong, overrun, abort, busy, 1'b0};
  endfunction

  initial begin
    rst      = 1'b1;
    rxStb    = 1'b0;
    rxData   = 8'h00;
    cmdReady = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_flags",  flags(),  32'h0);
    checkOutput("reset_opcode", {24'd0, opcode}, 32'h0);
    checkOutput("reset_data",   cmdData,  32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Short command with ready held high: valid for exactly one cycle
    applyStimulus(CMD_RUN);
    checkOutput("short_valid",  {31'd0, cmdValid}, 32'd1);
    checkOutput("short_opcode", {24'd0, opcode},   32'h01);
    checkOutput("short_data",   cmdData,           32'h0);
    checkOutput("short_islong", {31'd0, isLong},   32'd0);
    @(negedge clk);
    checkOutput("short_valid_drop", {31'd0, cmdValid}, 32'd0);
    checkOutput("short_busy_drop",  {31'd0, busy},     32'd0);

    // Short CMD_RESET opcode 0x00 is a real command too
    applyStimulus(CMD_RESET);
    checkOutput("zero_op_valid", {31'd0, cmdValid}, 32'd1);
    checkOutput("zero_op_opcode", {24'd0, opcode},  32'h00);
    @(negedge clk);

    // Long command, held until ready so the assembled argument can be inspected
    cmdReady = 1'b0;
    applyStimulus(8'hC0);
    checkOutput("long_collect_busy",  {30'd0, busy, cmdValid}, 32'b10);
    checkOutput("long_collect_islong", {31'd0, isLong},        32'd1);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    checkOutput("long_no_early_valid", {31'd0, cmdValid}, 32'd0);
    applyStimulus(8'h44);
    checkOutput("long_valid",  {31'd0, cmdValid}, 32'd1);
    checkOutput("long_opcode", {24'd0, opcode},   32'hC0);
    checkOutput("long_data",   cmdData,           32'h44332211);
    checkOutput("long_islong", {31'd0, isLong},   32'd1);
    cmdReady = 1'b1;
    @(negedge clk);
    checkOutput("long_taken", {30'd0, busy, cmdValid}, 32'b00);

    // Zero bytes inside COLLECT are data, not opcodes
    cmdReady = 1'b0;
    applyStimulus(8'h85);
    applyStimulus(8'h00);
    applyStimulus(8'hAB);
    applyStimulus(8'h00);
    applyStimulus(8'hCD);
    checkOutput("zero_bytes_valid", {31'd0, cmdValid}, 32'd1);
    checkOutput("zero_bytes_data",  cmdData,           32'hCD00AB00);
    cmdReady = 1'b1;
    @(negedge clk);

    // Backpressure: byte arriving mid-ISSUE is dropped with a single overrun pulse
    cmdReady = 1'b0;
    applyStimulus(CMD_RUN);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("bp_hold_%0d", i), {cmdValid, 15'd0, 8'd0, opcode}, {1'b1, 15'd0, 8'd0, 8'h01});
      checkOutput($sformatf("bp_data_%0d", i), cmdData, 32'h0);
      checkOutput($sformatf("bp_overrun_%0d", i), {31'd0, overrun}, (i == 5) ? 32'd1 : 32'd0);
      rxStb  = (i == 4);
      rxData = (i == 4) ? CMD_ID : 8'h00;
      @(negedge clk);
    end
    cmdReady = 1'b1;
    @(negedge clk);
    checkOutput("bp_one_cmd", {29'd0, busy, cmdValid, overrun}, 32'b000);

    // Byte coinciding with a handshake becomes the next opcode back-to-back
    rxStb  = 1'b1;
    rxData = CMD_RUN;
    @(negedge clk);
    checkOutput("b2b_first", {23'd0, cmdValid, opcode}, {23'd0, 1'b1, 8'h01});
    rxStb  = 1'b1;
    rxData = CMD_ID;
    @(negedge clk);
    rxStb  = 1'b0;
    rxData = 8'h00;
    checkOutput("b2b_second",  {23'd0, cmdValid, opcode}, {23'd0, 1'b1, 8'h02});
    checkOutput("b2b_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    checkOutput("b2b_done", {30'd0, cmdValid, overrun}, 32'b00);

    // Idle gap inside COLLECT
    applyStimulus(8'h80);
    applyStimulus(8'hAA);
`ifdef LOGIP_CMD_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("to_wait_%0d", k), {29'd0, cmdValid, abort, busy}, 32'b001);
      @(negedge clk);
    end
    checkOutput("to_abort", {29'd0, cmdValid, abort, busy}, 32'b010);
    @(negedge clk);
    checkOutput("to_abort_pulse", {31'd0, abort}, 32'd0);
    applyStimulus(CMD_RUN);
    checkOutput("to_recover", {23'd0, cmdValid, opcode}, {23'd0, 1'b1, 8'h01});
    @(negedge clk);
`else
    for (int k = 0; k < 20; k++) begin
      checkOutput($sformatf("nto_wait_%0d", k), {29'd0, cmdValid, abort, busy}, 32'b001);
      @(negedge clk);
    end
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    applyStimulus(8'hDD);
    checkOutput("nto_valid", {23'd0, cmdValid, opcode}, {23'd0, 1'b1, 8'h80});
    checkOutput("nto_data",  cmdData, 32'hDDCCBBAA);
    @(negedge clk);
`endif

    // Asynchronous reset in the middle of a long command
    cmdReady = 1'b0;
    applyStimulus(8'h81);
    applyStimulus(8'h01);
    checkOutput("rst_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_flags",  flags(), 32'h0);
    checkOutput("rst_async_opcode", {24'd0, opcode}, 32'h0);
    checkOutput("rst_async_data",   cmdData, 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    cmdReady = 1'b1;
    applyStimulus(CMD_META);
    checkOutput("rst_next_cmd", {22'd0, cmdValid, isLong, opcode}, {22'd0, 1'b1, 1'b0, 8'h04});
    checkOutput("rst_next_data", cmdData, 32'h0);
    @(negedge clk);
    checkOutput("rst_next_done", {31'd0, cmdValid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
